fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 13 +
 rtl/fetch_skid_buffer.sv | 37 +++
 rtl/fetch_stage.sv | 166 ++++++++++++++++
 tb/tb_fetch_stage.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding, FSM states, default PC width.
package fetch_stage_pkg;

    localparam int          PC_WIDTH_DEF = 16;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetch response that lands while IF/ID is stalled.
// Latency: captured value available the cycle after load; drained in one cycle.
// Backpressure: full flag tells the fetch FSM to stop issuing until the entry drains.
module fetch_skid_buffer
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic                drain,
    input  logic [31:0]         load_instr,
    input  logic [PC_WIDTH-1:0] load_pc,
    output logic                full,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one-at-a-time program-memory reads, drives IF/ID.
// Latency: request in cycle N, response at N+L, visible in IF/ID at N+L+1 (one per cycle at L=1).
// Backpressure: stall/flush hold off new requests; FETCH_SKID_BUFFER_EN keeps a stalled response instead of refetching.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pmem_addr,
    output logic                pmem_ren,
    input  logic [31:0]         pmem_rdata,
    input  logic                pmem_valid,
    input  logic                stall_fetch,
    input  logic                return_in_pipeline,
    input  logic                flush,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt,
    output logic [31:0]         if_id_instruction,
    output logic [PC_WIDTH-1:0] if_id_pc,
    output logic                if_id_valid
);

    fetch_state_t        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic                discard_q, discard_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic                ifid_vld_q, ifid_vld_d;
    logic                hold, outstanding, still_pending, issue;

`ifdef FETCH_SKID_BUFFER_EN
    logic                sb_load, sb_drain, sb_clear, sb_full;
    logic [31:0]         sb_instr;
    logic [PC_WIDTH-1:0] sb_pc;

    fetch_skid_buffer #(.PC_WIDTH(PC_WIDTH)) u_skid (
        .clk        (clk),
        .rst        (rst),
        .clear      (sb_clear),
        .load       (sb_load),
        .drain      (sb_drain),
        .load_instr (pmem_rdata),
        .load_pc    (pc_q),
        .full       (sb_full),
        .instr      (sb_instr),
        .pc         (sb_pc)
    );
`endif

    // Flush kills IF/ID and, like a stall, must not consume a response into it.
    assign hold          = flush | stall_fetch | return_in_pipeline;
    assign outstanding   = (state_q == S_WAIT) | discard_q;
    assign still_pending = outstanding & ~pmem_valid;
    assign pc_inc        = pc_q + PC_WIDTH'(1);
    assign pmem_ren      = issue & ~rst;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q & ~pmem_valid;
        instr_d    = instr_q;
        ifid_pc_d  = ifid_pc_q;
        ifid_vld_d = ifid_vld_q;
        issue      = 1'b0;
        pmem_addr  = pc_q;
`ifdef FETCH_SKID_BUFFER_EN
        sb_load    = 1'b0;
        sb_drain   = 1'b0;
        sb_clear   = 1'b0;
`endif
        if (redirect) begin
            pc_d       = redirect_pc;
            instr_d    = NOP_INSTR;
            ifid_vld_d = 1'b0;
            discard_d  = still_pending;
            state_d    = still_pending ? S_WAIT : S_FETCH;
`ifdef FETCH_SKID_BUFFER_EN
            sb_clear   = 1'b1;
`endif
        end else if (halt) begin
            // Any in-flight response is swallowed by the discard flag while halted.
            instr_d    = NOP_INSTR;
            ifid_vld_d = 1'b0;
            discard_d  = still_pending;
            state_d    = S_HALTED;
`ifdef FETCH_SKID_BUFFER_EN
            sb_clear   = 1'b1;
`endif
        end else begin
            if (flush) begin
                instr_d    = NOP_INSTR;
                ifid_vld_d = 1'b0;
            end
            case (state_q)
                S_FETCH: begin
                    if (!hold) begin
`ifdef FETCH_SKID_BUFFER_EN
                        if (sb_full) begin
                            instr_d    = sb_instr;
                            ifid_pc_d  = sb_pc;
                            ifid_vld_d = 1'b1;
                            sb_drain   = 1'b1;
                        end else begin
                            issue   = 1'b1;
                            state_d = S_WAIT;
                        end
`else
                        issue   = 1'b1;
                        state_d = S_WAIT;
`endif
                    end
                end
                S_WAIT: begin
                    if (pmem_valid) begin
                        if (discard_q) begin
                            state_d = S_FETCH;
                        end else if (!hold) begin
                            instr_d    = pmem_rdata;
                            ifid_pc_d  = pc_q;
                            ifid_vld_d = 1'b1;
                            pc_d       = pc_inc;
                            issue      = 1'b1;
                            pmem_addr  = pc_inc;
                        end else begin
                            state_d = S_FETCH;
`ifdef FETCH_SKID_BUFFER_EN
                            sb_load = 1'b1;
                            pc_d    = pc_inc;
`endif
                        end
                    end
                end
                S_HALTED: begin
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_VECTOR;
            discard_q  <= 1'b0;
            instr_q    <= NOP_INSTR;
            ifid_pc_q  <= '0;
            ifid_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            instr_q    <= instr_d;
            ifid_pc_q  <= ifid_pc_d;
            ifid_vld_q <= ifid_vld_d;
        end
    end

    assign if_id_instruction = instr_q;
    assign if_id_pc          = ifid_pc_q;
    assign if_id_valid       = ifid_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized stall/flush/latency run.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [15:0] RV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pmem_addr;
    logic        pmem_ren;
    logic [31:0] pmem_rdata = 32'h0;
    logic        pmem_valid = 1'b0;
    logic        stall_fetch = 1'b0;
    logic        return_in_pipeline = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic [31:0] if_id_instruction;
    logic [15:0] if_id_pc;
    logic        if_id_valid;

    int checks = 0;
    int failures = 0;

    fetch_stage #(.PC_WIDTH(16), .RESET_VECTOR(RV)) dut (
        .clk                (clk),
        .rst                (rst),
        .pmem_addr          (pmem_addr),
        .pmem_ren           (pmem_ren),
        .pmem_rdata         (pmem_rdata),
        .pmem_valid         (pmem_valid),
        .stall_fetch        (stall_fetch),
        .return_in_pipeline (return_in_pipeline),
        .flush              (flush),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .halt               (halt),
        .if_id_instruction  (if_id_instruction),
        .if_id_pc           (if_id_pc),
        .if_id_valid        (if_id_valid)
    );

    always #5 clk = ~clk;

    // Program memory model: in-order responses after a fixed or random latency.
    typedef struct packed {
        int          due;
        logic [15:0] addr;
    } req_t;
    req_t        rq[$];
    int          cyc = 0;
    int          last_due = 0;
    int          lat_mode = 0;
    int          fix_lat = 1;
    int          rsp_due;
    logic        plan_data = 1'b0;
    logic [31:0] seed = 32'h1234_5678;

    function automatic logic [31:0] data_of(input logic [15:0] a);
        if (plan_data && a == 16'h0000) return 32'hBC00_0001;
        if (plan_data && a == 16'h0001) return 32'h8000_0002;
        return {a ^ seed[31:16], ~a ^ seed[15:0]};
    endfunction

    always @(posedge clk) begin
        if (pmem_ren === 1'b1) begin
            rsp_due = cyc + ((lat_mode == 0) ? fix_lat : int'($urandom_range(1, 4)));
            if (rsp_due <= last_due) rsp_due = last_due + 1;
            rq.push_back('{due: rsp_due, addr: pmem_addr});
            last_due = rsp_due;
        end
        cyc++;
        #1;
        pmem_valid = 1'b0;
        pmem_rdata = $urandom;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            pmem_valid = 1'b1;
            pmem_rdata = data_of(rq[0].addr);
            void'(rq.pop_front());
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_fetch = 1'b0; return_in_pipeline = 1'b0; flush = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
        repeat (6) next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b0 || if_id_valid !== 1'b0 || if_id_instruction !== NOP_INSTR || if_id_pc !== 16'h0) begin
            failures++;
            $display("FAIL reset_state ren=%b vld=%b instr=%h pc=%h required 0/0/00000000/0000",
                     pmem_ren, if_id_valid, if_id_instruction, if_id_pc);
        end
        repeat (5) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== RV) begin
            failures++;
            $display("FAIL reset_first_req ren=%b addr=%h required 1/%h", pmem_ren, pmem_addr, RV);
        end
    endtask

    task automatic test_basic();
        lat_mode = 0; fix_lat = 1; plan_data = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (pmem_ren !== 1'b1 || pmem_addr !== 16'(c)) begin
                failures++;
                $display("FAIL basic_req%0d ren=%b addr=%h required 1/%h", c, pmem_ren, pmem_addr, 16'(c));
            end
            if (c == 1) begin
                checks++;
                if (if_id_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL basic_empty vld=%b required 0", if_id_valid);
                end
            end
            if (c == 2) begin
                checks++;
                if (if_id_instruction !== 32'hBC00_0001 || if_id_pc !== 16'h0 || if_id_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL basic_ifid0 instr=%h pc=%h vld=%b required bc000001/0000/1",
                             if_id_instruction, if_id_pc, if_id_valid);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (if_id_instruction !== 32'h8000_0002 || if_id_pc !== 16'h1 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_ifid1 instr=%h pc=%h vld=%b required 80000002/0001/1",
                     if_id_instruction, if_id_pc, if_id_valid);
        end
        plan_data = 1'b0;
    endtask

    task automatic test_stall();
        lat_mode = 0; fix_lat = 1; seed = $urandom;
        do_reset();
        next_cycle();
        next_cycle();
        for (int c = 2; c < 5; c++) begin
            stall_fetch        = (c != 3);
            return_in_pipeline = (c != 2);
            @(negedge clk);
            checks++;
            if (pmem_ren !== 1'b0 || if_id_instruction !== data_of(16'h0) || if_id_pc !== 16'h0 || if_id_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold_c%0d ren=%b instr=%h pc=%h vld=%b required 0/%h/0000/1",
                         c, pmem_ren, if_id_instruction, if_id_pc, if_id_valid, data_of(16'h0));
            end
            next_cycle();
        end
        stall_fetch = 1'b0; return_in_pipeline = 1'b0;
        @(negedge clk);
`ifdef FETCH_SKID_BUFFER_EN
        checks++;
        if (pmem_ren !== 1'b0 || if_id_pc !== 16'h0) begin
            failures++;
            $display("FAIL stall_release ren=%b ifid_pc=%h required 0/0000", pmem_ren, if_id_pc);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_id_instruction !== data_of(16'h1) || if_id_pc !== 16'h1 || pmem_ren !== 1'b1 || pmem_addr !== 16'h2) begin
            failures++;
            $display("FAIL stall_drain instr=%h pc=%h ren=%b addr=%h required %h/0001/1/0002",
                     if_id_instruction, if_id_pc, pmem_ren, pmem_addr, data_of(16'h1));
        end
`else
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== 16'h1 || if_id_pc !== 16'h0) begin
            failures++;
            $display("FAIL stall_refetch ren=%b addr=%h ifid_pc=%h required 1/0001/0000", pmem_ren, pmem_addr, if_id_pc);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_id_instruction !== data_of(16'h1) || if_id_pc !== 16'h1 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_after instr=%h pc=%h vld=%b required %h/0001/1",
                     if_id_instruction, if_id_pc, if_id_valid, data_of(16'h1));
        end
`endif
    endtask

    task automatic test_redirect();
        lat_mode = 0; fix_lat = 3; seed = $urandom;
        do_reset();
        redirect = 1'b1; redirect_pc = 16'h0005;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b0) begin
            failures++;
            $display("FAIL redir_cycle ren=%b required 0", pmem_ren);
        end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== 16'h0005) begin
            failures++;
            $display("FAIL redir_n1 ren=%b addr=%h required 1/0005", pmem_ren, pmem_addr);
        end
        next_cycle();
        redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        next_cycle();
        redirect = 1'b0;
        for (int c = 3; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (if_id_valid !== 1'b0 || if_id_instruction !== NOP_INSTR) begin
                failures++;
                $display("FAIL redir_nop_c%0d vld=%b instr=%h required 0/00000000", c, if_id_valid, if_id_instruction);
            end
            checks++;
            if (pmem_ren !== (c == 5 || c == 8) ||
                (c == 5 && pmem_addr !== 16'h0040) || (c == 8 && pmem_addr !== 16'h0041)) begin
                failures++;
                $display("FAIL redir_req_c%0d ren=%b addr=%h", c, pmem_ren, pmem_addr);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (if_id_instruction !== data_of(16'h0040) || if_id_pc !== 16'h0040 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL redir_target instr=%h pc=%h vld=%b required %h/0040/1",
                     if_id_instruction, if_id_pc, if_id_valid, data_of(16'h0040));
        end
    endtask

    task automatic test_halt();
        lat_mode = 0; fix_lat = 1; seed = $urandom;
        do_reset();
        next_cycle();
        next_cycle();
        halt = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b0) begin
            failures++;
            $display("FAIL halt_cycle ren=%b required 0", pmem_ren);
        end
        next_cycle();
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (pmem_ren !== 1'b0 || if_id_instruction !== NOP_INSTR || if_id_valid !== 1'b0) begin
                failures++;
                $display("FAIL halted_%0d ren=%b instr=%h vld=%b required 0/00000000/0",
                         i, pmem_ren, if_id_instruction, if_id_valid);
            end
            next_cycle();
        end
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge clk);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== 16'h0100) begin
            failures++;
            $display("FAIL halt_resume ren=%b addr=%h required 1/0100", pmem_ren, pmem_addr);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_id_instruction !== data_of(16'h0100) || if_id_pc !== 16'h0100 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_resume_ifid instr=%h pc=%h vld=%b required %h/0100/1",
                     if_id_instruction, if_id_pc, if_id_valid, data_of(16'h0100));
        end
    endtask

    task automatic test_wrap();
        lat_mode = 0; fix_lat = 1; seed = $urandom;
        do_reset();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_addr ren=%b addr=%h required 1/0000", pmem_ren, pmem_addr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_id_pc !== 16'hFFFF || if_id_instruction !== data_of(16'hFFFF)) begin
            failures++;
            $display("FAIL wrap_ifid pc=%h instr=%h required ffff/%h", if_id_pc, if_id_instruction, data_of(16'hFFFF));
        end
    endtask

    task automatic test_reset_mid();
        lat_mode = 0; fix_lat = 4; seed = $urandom;
        do_reset();
        redirect = 1'b1; redirect_pc = 16'h0033;
        next_cycle();
        redirect = 1'b0;
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        stall_fetch = 1'b1;
        for (int c = 3; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (pmem_ren !== 1'b0 || if_id_valid !== 1'b0) begin
                failures++;
                $display("FAIL rstmid_idle_c%0d ren=%b vld=%b required 0/0", c, pmem_ren, if_id_valid);
            end
            next_cycle();
        end
        stall_fetch = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_ren !== 1'b1 || pmem_addr !== RV) begin
            failures++;
            $display("FAIL rstmid_restart ren=%b addr=%h required 1/%h", pmem_ren, pmem_addr, RV);
        end
        repeat (5) next_cycle();
        @(negedge clk);
        checks++;
        if (if_id_instruction !== data_of(RV) || if_id_pc !== RV || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ifid instr=%h pc=%h vld=%b required %h/%h/1",
                     if_id_instruction, if_id_pc, if_id_valid, data_of(RV), RV);
        end
    endtask

    // Stream-level model: IF/ID must present consecutive PCs with matching data, no skips or repeats.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [31:0] p_instr;
        logic [15:0] p_pc;
        logic        p_vld, p_hold, p_flush;
        int          delivered;
        lat_mode = 1; seed = $urandom;
        do_reset();
        exp_pc = RV; delivered = 0;
        p_vld = 1'b0; p_pc = 16'h0; p_instr = 32'h0; p_hold = 1'b0; p_flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            stall_fetch        = ($urandom_range(0, 3) == 0);
            return_in_pipeline = ($urandom_range(0, 7) == 0);
            flush              = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            if (p_flush) begin
                checks++;
                if (if_id_valid !== 1'b0 || if_id_instruction !== NOP_INSTR) begin
                    failures++;
                    $display("FAIL rnd_flush c=%0d vld=%b instr=%h required 0/00000000", c, if_id_valid, if_id_instruction);
                end
            end else if (p_hold) begin
                checks++;
                if (if_id_valid !== p_vld || if_id_pc !== p_pc || if_id_instruction !== p_instr) begin
                    failures++;
                    $display("FAIL rnd_hold c=%0d vld=%b pc=%h instr=%h required %b/%h/%h",
                             c, if_id_valid, if_id_pc, if_id_instruction, p_vld, p_pc, p_instr);
                end
            end
            if (if_id_valid === 1'b1 && (!p_vld || if_id_pc !== p_pc)) begin
                checks++;
                if (if_id_pc !== exp_pc || if_id_instruction !== data_of(exp_pc)) begin
                    failures++;
                    $display("FAIL rnd_order c=%0d pc=%h instr=%h required %h/%h",
                             c, if_id_pc, if_id_instruction, exp_pc, data_of(exp_pc));
                    exp_pc = if_id_pc;
                end
                exp_pc = exp_pc + 16'd1;
                delivered++;
            end
            if (stall_fetch || return_in_pipeline) begin
                checks++;
                if (pmem_ren !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_stall_req c=%0d ren=%b required 0", c, pmem_ren);
                end
            end
            if (pmem_ren === 1'b1) begin
                checks++;
                if ((pmem_addr !== exp_pc && pmem_addr !== exp_pc + 16'd1) || rq.size() != 0) begin
                    failures++;
                    $display("FAIL rnd_req c=%0d addr=%h pending=%0d required %h or %h with 0 pending",
                             c, pmem_addr, rq.size(), exp_pc, exp_pc + 16'd1);
                end
            end
            p_vld = if_id_valid; p_pc = if_id_pc; p_instr = if_id_instruction;
            p_hold = stall_fetch | return_in_pipeline; p_flush = flush;
            next_cycle();
        end
        stall_fetch = 1'b0; return_in_pipeline = 1'b0; flush = 1'b0;
        checks++;
        if (delivered < 20) begin
            failures++;
            $display("FAIL rnd_progress delivered=%0d required >=20", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
